braille_rotor_driver: RTL and testbench

BRAILLE_ROTOR_DRIVER -- requirements
Module: braille_rotor_driver

---
 rtl/braille_rotor_driver.sv | 199 +++++++++++++++++++
 tb/tb_braille_rotor_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/braille_rotor_driver.sv
`default_nettype none
// ============================================================================
//  Module   : braille_rotor_driver
//  Function : Positions two 8-face braille rotors (left/right column) to the
//             dot patterns of an incoming code. Each rotor advances one face
//             per step pulse. Steps are spaced STEP_DIV clocks apart, and a
//             SETTLE_CYC dwell follows the last step before done is pulsed.
//  Options  : ROTOR_BIDIR_EN - adds dir_l/dir_r outputs and takes the
//             shorter path (reverse for 5..7 faces away).
//  Revision : 1.0 - initial release
// ============================================================================
module braille_rotor_driver #(
    parameter int unsigned STEP_DIV   = 1000,
    parameter int unsigned SETTLE_CYC = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       step_l,
    output logic       step_r,
    output logic [2:0] pos_l,
    output logic [2:0] pos_r,
    output logic       busy,
    output logic       done
`ifdef ROTOR_BIDIR_EN
    ,
    output logic       dir_l,
    output logic       dir_r
`endif
);

    localparam logic [15:0] c_DIV_LAST    = 16'(STEP_DIV - 1);
    localparam logic [15:0] c_SETTLE_LAST = 16'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_STEP   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
    logic [2:0]  pos_l_q, pos_l_d, pos_r_q, pos_r_d;
    logic [2:0]  rem_l_q, rem_l_d, rem_r_q, rem_r_d;
    logic [15:0] div_q, div_d;
    logic [15:0] settle_q, settle_d;
    logic        w_pulse;
    logic [2:0]  w_raw_l, w_raw_r;
    logic        w_unused;

    // Code bits [1:0] carry no dot information.
    assign w_unused = &{1'b0, in_data[1:0]};

    // Forward face distance from the current face to the target face.
    assign w_raw_l = tgt_l_q - pos_l_q;
    assign w_raw_r = tgt_r_q - pos_r_q;

`ifdef ROTOR_BIDIR_EN
    logic       dir_l_q, dir_l_d, dir_r_q, dir_r_d;
    logic [2:0] w_in_raw_l, w_in_raw_r;

    // Direction is decided at accept so it is already valid during CALC.
    assign w_in_raw_l = in_data[7:5] - pos_l_q;
    assign w_in_raw_r = in_data[4:2] - pos_r_q;
    assign dir_l      = dir_l_q;
    assign dir_r      = dir_r_q;
`endif

    // State, position and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tgt_l_q  <= 3'd0;
            tgt_r_q  <= 3'd0;
            pos_l_q  <= 3'd0;
            pos_r_q  <= 3'd0;
            rem_l_q  <= 3'd0;
            rem_r_q  <= 3'd0;
            div_q    <= 16'd0;
            settle_q <= 16'd0;
`ifdef ROTOR_BIDIR_EN
            dir_l_q  <= 1'b0;
            dir_r_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tgt_l_q  <= tgt_l_d;
            tgt_r_q  <= tgt_r_d;
            pos_l_q  <= pos_l_d;
            pos_r_q  <= pos_r_d;
            rem_l_q  <= rem_l_d;
            rem_r_q  <= rem_r_d;
            div_q    <= div_d;
            settle_q <= settle_d;
`ifdef ROTOR_BIDIR_EN
            dir_l_q  <= dir_l_d;
            dir_r_q  <= dir_r_d;
`endif
        end
    end

    // Next-state logic: sequencing, step timing and face tracking.
    always_comb begin
        state_d  = state_q;
        tgt_l_d  = tgt_l_q;
        tgt_r_d  = tgt_r_q;
        pos_l_d  = pos_l_q;
        pos_r_d  = pos_r_q;
        rem_l_d  = rem_l_q;
        rem_r_d  = rem_r_q;
        div_d    = div_q;
        settle_d = settle_q;
        w_pulse  = 1'b0;
`ifdef ROTOR_BIDIR_EN
        dir_l_d  = dir_l_q;
        dir_r_d  = dir_r_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    tgt_l_d = in_data[7:5];
                    tgt_r_d = in_data[4:2];
`ifdef ROTOR_BIDIR_EN
                    dir_l_d = (w_in_raw_l >= 3'd5);
                    dir_r_d = (w_in_raw_r >= 3'd5);
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
`ifdef ROTOR_BIDIR_EN
                rem_l_d = dir_l_q ? (3'd0 - w_raw_l) : w_raw_l;
                rem_r_d = dir_r_q ? (3'd0 - w_raw_r) : w_raw_r;
`else
                rem_l_d = w_raw_l;
                rem_r_d = w_raw_r;
`endif
                div_d   = 16'd0;
                state_d = ((rem_l_d == 3'd0) && (rem_r_d == 3'd0)) ? S_DONE : S_STEP;
            end
            S_STEP: begin
                if (div_q == c_DIV_LAST) begin
                    w_pulse = 1'b1;
                    div_d   = 16'd0;
                    if (rem_l_q != 3'd0) begin
`ifdef ROTOR_BIDIR_EN
                        pos_l_d = dir_l_q ? (pos_l_q - 3'd1) : (pos_l_q + 3'd1);
`else
                        pos_l_d = pos_l_q + 3'd1;
`endif
                        rem_l_d = rem_l_q - 3'd1;
                    end
                    if (rem_r_q != 3'd0) begin
`ifdef ROTOR_BIDIR_EN
                        pos_r_d = dir_r_q ? (pos_r_q - 3'd1) : (pos_r_q + 3'd1);
`else
                        pos_r_d = pos_r_q + 3'd1;
`endif
                        rem_r_d = rem_r_q - 3'd1;
                    end
                    if ((rem_l_d == 3'd0) && (rem_r_d == 3'd0)) begin
                        settle_d = 16'd0;
                        state_d  = S_SETTLE;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (settle_q == c_SETTLE_LAST) begin
                    state_d = S_DONE;
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulses are suppressed while reset is asserted so an abort never steps.
    assign step_l   = w_pulse && (rem_l_q != 3'd0) && !rst;
    assign step_r   = w_pulse && (rem_r_q != 3'd0) && !rst;
    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE) && !rst;
    assign pos_l    = pos_l_q;
    assign pos_r    = pos_r_q;

endmodule
`default_nettype wire

// File: tb/tb_braille_rotor_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_braille_rotor_driver
//  Function : Randomized and directed bench for braille_rotor_driver against
//             a face-distance reference model (STEP_DIV=4, SETTLE_CYC=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_braille_rotor_driver;

    localparam int c_D = 4;
    localparam int c_S = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, step_l, step_r, busy, done;
    logic [2:0] pos_l, pos_r;
`ifdef ROTOR_BIDIR_EN
    logic       dir_l, dir_r;
`endif

    int n_chk = 0;
    int n_err = 0;
    int mpos_l = 0;
    int mpos_r = 0;

    braille_rotor_driver #(.STEP_DIV(c_D), .SETTLE_CYC(c_S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .step_l   (step_l),
        .step_r   (step_r),
        .pos_l    (pos_l),
        .pos_r    (pos_r),
        .busy     (busy),
        .done     (done)
`ifdef ROTOR_BIDIR_EN
        ,
        .dir_l    (dir_l),
        .dir_r    (dir_r)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: number of faces to move and direction for one rotor.
    function automatic void plan(input int pos, input int tgt, output int n, output int dir);
        int raw;
        raw = (tgt - pos + 8) % 8;
        n   = raw;
        dir = 0;
`ifdef ROTOR_BIDIR_EN
        if (raw >= 5) begin
            n   = 8 - raw;
            dir = 1;
        end
`endif
    endfunction

    // One full operation: accept, monitor pulses/done, compare with the model.
    task automatic do_op(input logic [7:0] code, input bit hold, input string tag);
        int tl, tr, nl, nr, dl, dr, n, exp_lat;
        int cl, cr, bad, brdy, done_t, waits;
        int dir_obs_l, dir_obs_r;
        cl = 0; cr = 0; bad = 0; brdy = 0; done_t = -1; waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = code;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check_eq({tag, "_ready"}, int'(in_ready), 1);
        tl = int'(code[7:5]);
        tr = int'(code[4:2]);
        plan(mpos_l, tl, nl, dl);
        plan(mpos_r, tr, nr, dr);
        n       = (nl > nr) ? nl : nr;
        exp_lat = (n == 0) ? 1 : 1 + n * c_D + c_S;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        for (int t = 1; t <= 200; t++) begin
            @(posedge clk);
            #1;
            dir_obs_l = dl;
            dir_obs_r = dr;
`ifdef ROTOR_BIDIR_EN
            dir_obs_l = int'(dir_l);
            dir_obs_r = int'(dir_r);
`endif
            if (dir_obs_l != dl || dir_obs_r != dr) bad++;
            if (step_l) begin
                cl++;
                if ((t % c_D) != 0 || (t / c_D) > nl) bad++;
            end
            if (step_r) begin
                cr++;
                if ((t % c_D) != 0 || (t / c_D) > nr) bad++;
            end
            if (in_ready) brdy++;
            if (done) begin
                done_t = t;
                break;
            end
        end
        check_eq({tag, "_lat"},   done_t, exp_lat);
        check_eq({tag, "_nl"},    cl, nl);
        check_eq({tag, "_nr"},    cr, nr);
        check_eq({tag, "_tim"},   bad, 0);
        check_eq({tag, "_rdy"},   brdy, 0);
        check_eq({tag, "_posl"},  int'(pos_l), tl);
        check_eq({tag, "_posr"},  int'(pos_r), tr);
        mpos_l = tl;
        mpos_r = tr;
    endtask

    initial begin
        int pulses, seen;
        logic [7:0] code;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_posl",  int'(pos_l), 0);
        check_eq("rst_posr",  int'(pos_r), 0);
        check_eq("rst_ready", int'(in_ready), 1);
        check_eq("rst_busy",  int'(busy), 0);
        check_eq("rst_done",  int'(done), 0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            pulses += int'(step_l) + int'(step_r);
        end
        check_eq("rst_steps", pulses, 0);

        // Directed sequence
        do_op(8'h80, 1'b0, "a80");
        do_op(8'h80, 1'b0, "r80");
        do_op(8'h74, 1'b0, "a74");

        // Held valid: second accept only on the first IDLE cycle
        do_op(8'h48, 1'b1, "h48");
        @(posedge clk); #1;
        check_eq("h48_idle_rdy", int'(in_ready), 1);
        @(posedge clk); #1;
        check_eq("h48_reacc", int'(busy), 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("h48_done0", int'(done), 1);
        @(posedge clk); #1;
        check_eq("h48_idle1", int'(busy), 0);
        @(posedge clk); #1;
        check_eq("h48_idle2", int'(busy), 0);
        check_eq("h48_posl", int'(pos_l), 2);
        check_eq("h48_posr", int'(pos_r), 2);

        // Reset during STEP after two pulses
        code = {3'((mpos_l + 3) % 8), 3'((mpos_r + 3) % 8), 2'b00};
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = code;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int t = 0; t < 100 && seen < 2; t++) begin
            @(posedge clk); #1;
            if (step_l) seen++;
        end
        check_eq("ab_pulses", seen, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("ab_posl", int'(pos_l), 0);
        check_eq("ab_posr", int'(pos_r), 0);
        check_eq("ab_idle", int'(in_ready), 1);
        check_eq("ab_busy", int'(busy), 0);
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            pulses += int'(step_l) + int'(step_r) + int'(done);
        end
        check_eq("ab_quiet", pulses, 0);
        mpos_l = 0;
        mpos_r = 0;

        // Randomized codes
        for (int i = 0; i < 12; i++) begin
            code = 8'($urandom);
            do_op(code, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
